game_controller: RTL and testbench

Top-level game sequencer for Space Invaders, clocked in the 36 MHz pixel domain beside `gameplay`, `player` and `invaders`. It runs the game through attract, playing, paused, level-clear and game-over phases, and decides when each happens. It drives the `enable`, `clear`, `clear_score` and `level` controls consumed by `player` and `invaders`, and publishes the phase code on `gameplay` for `sprite_drawer`. It is paced by a one-cycle-per-frame tick, so all delays are measured in video frames.

---
 rtl/game_controller.sv | 134 +++++++++++++
 tb/tb_game_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Frame-paced game phase sequencer: attract, playing, paused, level-clear and
// game-over, driving the enable/clear/score/level controls for the play field.
module game_controller #(
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned INVADE_LINE  = 11
) (
  input  logic        clk_36MHz,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_debounced,
  input  logic [19:0] invaders_array,
  input  logic [3:0]  invaders_line,
  output logic [2:0]  gameplay,
  output logic        enable,
  output logic        clear,
  output logic        clear_score,
  output logic        level,
  output logic [3:0]  wave
);

  typedef enum logic [2:0] {
    ATTRACT     = 3'd0,
    PLAYING     = 3'd1,
    LEVEL_CLEAR = 3'd2,
    GAME_OVER   = 3'd3,
    PAUSED      = 3'd4
  } state_e;

  localparam logic [8:0] CLEAR_LAST = 9'(CLEAR_FRAMES);
  localparam logic [8:0] OVER_LAST  = 9'(OVER_FRAMES);
  localparam logic [4:0] LINE_LIM   = 5'(INVADE_LINE);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        enable_q, enable_d;
  logic        clear_q, clear_d;
  logic        clear_score_q, clear_score_d;
  logic        level_q, level_d;
  logic [3:0]  wave_q, wave_d;
  logic [8:0]  cnt_inc;
  logic        breach;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign breach  = ({1'b0, invaders_line} >= LINE_LIM);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    clear_d       = 1'b0;
    clear_score_d = 1'b0;
    level_d       = level_q;
    wave_d        = wave_q;

    if (frame_tick) cnt_d = cnt_inc[7:0];

    unique case (state_q)
      ATTRACT: begin
        cnt_d = '0;
        if (start_debounced) begin
          state_d       = PLAYING;
          clear_d       = 1'b1;
          clear_score_d = 1'b1;
          wave_d        = '0;
          level_d       = 1'b0;
          armed_d       = 1'b0;
        end
      end
      PLAYING: begin
        if (frame_tick) armed_d = 1'b1;
        // Inputs are only trusted once the invaders have reloaded (first tick).
        if (armed_q) begin
          if (invaders_array == '0)  state_d = LEVEL_CLEAR;
          else if (breach)           state_d = GAME_OVER;
          else if (start_debounced)  state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (start_debounced) state_d = PLAYING;
      end
      LEVEL_CLEAR: begin
        if (frame_tick && cnt_inc == CLEAR_LAST) begin
          state_d = PLAYING;
          clear_d = 1'b1;
          armed_d = 1'b0;
          level_d = 1'b1;
          if (wave_q != 4'd15) wave_d = wave_q + 4'd1;
        end
      end
      GAME_OVER: begin
        if (frame_tick && cnt_inc == OVER_LAST) state_d = ATTRACT;
      end
      default: state_d = ATTRACT;
    endcase

    // A tick coinciding with a transition belongs to the state being left.
    if (state_d != state_q) cnt_d = '0;
  end

  assign enable_d = (state_d == PLAYING);

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state_q       <= ATTRACT;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      enable_q      <= 1'b0;
      clear_q       <= 1'b0;
      clear_score_q <= 1'b0;
      level_q       <= 1'b0;
      wave_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      enable_q      <= enable_d;
      clear_q       <= clear_d;
      clear_score_q <= clear_score_d;
      level_q       <= level_d;
      wave_q        <= wave_d;
    end
  end

  // The phase register doubles as the externally visible phase code.
  assign gameplay    = state_q;
  assign enable      = enable_q;
  assign clear       = clear_q;
  assign clear_score = clear_score_q;
  assign level       = level_q;
  assign wave        = wave_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed vector bench for game_controller with short dwell parameters.
module tb_game_controller;

  localparam int unsigned CLEAR_FRAMES = 3;
  localparam int unsigned OVER_FRAMES  = 4;

  logic        clk_36MHz = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start_debounced = 1'b0;
  logic [19:0] invaders_array = 20'hFFFFF;
  logic [3:0]  invaders_line = 4'd0;
  logic [2:0]  gameplay;
  logic        enable, clear, clear_score, level;
  logic [3:0]  wave;

  game_controller #(
    .CLEAR_FRAMES(CLEAR_FRAMES),
    .OVER_FRAMES (OVER_FRAMES),
    .INVADE_LINE (11)
  ) dut (
    .clk_36MHz      (clk_36MHz),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .start_debounced(start_debounced),
    .invaders_array (invaders_array),
    .invaders_line  (invaders_line),
    .gameplay       (gameplay),
    .enable         (enable),
    .clear          (clear),
    .clear_score    (clear_score),
    .level          (level),
    .wave           (wave)
  );

  // clock / reset
  always #5 clk_36MHz = ~clk_36MHz;

  typedef struct {
    logic        rst;
    logic        start;
    logic        tick;
    logic [19:0] arr;
    logic [3:0]  line;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  // {gameplay, enable, clear, clear_score, level, wave}
  function automatic logic [10:0] pk(input logic [2:0] gp, input logic en, input logic cl,
                                     input logic cs, input logic lv, input logic [3:0] wv);
    return {gp, en, cl, cs, lv, wv};
  endfunction

  function automatic void add(input logic rst, input logic start, input logic tick,
                              input logic [19:0] arr, input logic [3:0] line,
                              input logic [10:0] exp);
    vec_t v;
    v.rst = rst; v.start = start; v.tick = tick; v.arr = arr; v.line = line; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // driver: apply one cycle of inputs, return 1 time unit after the edge
  task automatic step(input logic rst, input logic start, input logic tick,
                      input logic [19:0] arr, input logic [3:0] line);
    @(negedge clk_36MHz);
    reset           = rst;
    start_debounced = start;
    frame_tick      = tick;
    invaders_array  = arr;
    invaders_line   = line;
    @(posedge clk_36MHz);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {gameplay, enable, clear, clear_score, level, wave};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got gp=%0d en=%0b clr=%0b cs=%0b lv=%0b wave=%0d, want gp=%0d en=%0b clr=%0b cs=%0b lv=%0b wave=%0d",
                  name, act[10:8], act[7], act[6], act[5], act[4], act[3:0],
                  exp[10:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
  endtask

  localparam logic [19:0] FULL = 20'hFFFFF;

  initial begin
    int exp_wave;

    // nominal flow: start, unarmed ignores, clear a wave, priority, reset mid clear
    add(0,0,0,FULL,0,  pk(0,0,0,0,0,0));
    add(0,1,0,FULL,0,  pk(1,1,1,1,0,0));
    add(0,0,0,FULL,0,  pk(1,1,0,0,0,0));
    add(0,0,0,0,0,     pk(1,1,0,0,0,0));
    add(0,1,0,FULL,0,  pk(1,1,0,0,0,0));
    add(0,0,1,0,0,     pk(1,1,0,0,0,0));
    add(0,0,0,0,0,     pk(2,0,0,0,0,0));
    add(0,0,1,0,0,     pk(2,0,0,0,0,0));
    add(0,0,0,0,0,     pk(2,0,0,0,0,0));
    add(0,0,1,0,0,     pk(2,0,0,0,0,0));
    add(0,0,1,0,0,     pk(1,1,1,0,1,1));
    add(0,0,0,FULL,0,  pk(1,1,0,0,1,1));
    add(0,0,1,FULL,0,  pk(1,1,0,0,1,1));
    add(0,0,0,0,11,    pk(2,0,0,0,1,1));
    add(1,0,1,0,0,     pk(0,0,0,0,0,0));
    add(0,0,0,FULL,0,  pk(0,0,0,0,0,0));
    add(0,0,1,FULL,0,  pk(0,0,0,0,0,0));
    // pause / resume, armed survives a pause
    add(0,1,0,FULL,0,  pk(1,1,1,1,0,0));
    add(0,0,1,FULL,0,  pk(1,1,0,0,0,0));
    add(0,1,0,FULL,0,  pk(4,0,0,0,0,0));
    add(0,0,1,0,15,    pk(4,0,0,0,0,0));
    add(0,1,0,FULL,0,  pk(1,1,0,0,0,0));
    add(0,1,0,FULL,0,  pk(4,0,0,0,0,0));
    add(0,1,0,FULL,0,  pk(1,1,0,0,0,0));
    // tick in the transition cycle does not count toward LEVEL_CLEAR
    add(0,0,1,0,0,     pk(2,0,0,0,0,0));
    add(0,0,1,0,0,     pk(2,0,0,0,0,0));
    add(0,0,1,0,0,     pk(2,0,0,0,0,0));
    add(0,0,1,FULL,0,  pk(1,1,1,0,1,1));
    add(0,0,1,FULL,0,  pk(1,1,0,0,1,1));
    // game over, start ignored, wave/level held, back to attract
    add(0,0,0,FULL,11, pk(3,0,0,0,1,1));
    add(0,0,1,FULL,0,  pk(3,0,0,0,1,1));
    add(0,1,0,FULL,0,  pk(3,0,0,0,1,1));
    add(0,0,1,FULL,0,  pk(3,0,0,0,1,1));
    add(0,1,1,FULL,0,  pk(3,0,0,0,1,1));
    add(0,0,1,FULL,0,  pk(0,0,0,0,1,1));
    add(0,0,0,FULL,0,  pk(0,0,0,0,1,1));
    add(0,1,0,FULL,0,  pk(1,1,1,1,0,0));

    // reset held, then long idle
    repeat (3) @(posedge clk_36MHz);
    step(1, 0, 0, FULL, 0);
    check("reset_state", pk(0,0,0,0,0,0));
    for (int i = 0; i < 1000; i++) begin
      step(0, 0, (i % 7) == 0, FULL, 0);
      check("idle_attract", pk(0,0,0,0,0,0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].tick, vecs[i].arr, vecs[i].line);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // 16 wave clears from a fresh game: wave saturates at 15
    for (int i = 0; i < 16; i++) begin
      exp_wave = (i > 15) ? 15 : i;
      step(0, 0, 1, FULL, 0);
      check($sformatf("sat_arm%0d", i), pk(1,1,0,0, i != 0, 4'(exp_wave)));
      step(0, 0, 0, 0, 0);
      check($sformatf("sat_lc%0d", i), pk(2,0,0,0, i != 0, 4'(exp_wave)));
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      check($sformatf("sat_dwell%0d", i), pk(2,0,0,0, i != 0, 4'(exp_wave)));
      step(0, 0, 1, 0, 0);
      exp_wave = (i + 1 > 15) ? 15 : i + 1;
      check($sformatf("sat_next%0d", i), pk(1,1,1,0,1, 4'(exp_wave)));
    end
    step(0, 0, 0, FULL, 0);
    check("sat_clear_drop", pk(1,1,0,0,1,15));

    // reset in PLAYING right after a clear pulse
    step(1, 0, 0, FULL, 0);
    check("reset_playing", pk(0,0,0,0,0,0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
